// File: rtl/uart_pkt_pkg.sv
// Shared types and error codes for the UART packet deframer.
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_pkt_rx.sv
// Packet deframer behind the UART RX FIFO: SOF hunt, LEN, payload stream, additive checksum.
// Optional inter-byte timeout is built only when UART_PKT_TIMEOUT_EN is defined.
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0]  SOF         = 8'hA5,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0] LP_MAX_LEN = 8'(MAX_LEN);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_sum, w_sum_nxt;
  logic       r_m_valid, w_m_valid_nxt;
  logic [7:0] r_m_data, w_m_data_nxt;
  logic       r_m_last, w_m_last_nxt;
  logic       r_pkt_ok, w_pkt_ok_nxt;
  logic       r_pkt_err, w_pkt_err_nxt;
  logic [1:0] r_err_code, w_err_code_nxt;

  logic       w_accept;
  logic       w_pop;
  logic [7:0] w_sum_add;
  logic       w_tmo_expire;

  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      IDLE, LEN: w_accept = 1'b1;
      PAYLOAD:   w_accept = ~r_m_valid | m_ready;
      CSUM:      w_accept = ~r_m_valid;
      default:   w_accept = 1'b0;
    endcase
  end

  assign w_pop     = ~rx_empty & w_accept;
  assign w_sum_add = r_sum + r_data;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TmoW-1:0] r_tmo, w_tmo_nxt;

  // Counts only while starved by the FIFO; a downstream stall or any pop restarts it.
  always_comb begin
    w_tmo_nxt    = '0;
    w_tmo_expire = 1'b0;
    if (r_state != IDLE && w_accept && rx_empty) begin
      if (r_tmo == TmoW'(TIMEOUT_CYC - 1)) begin
        w_tmo_expire = 1'b1;
      end else begin
        w_tmo_nxt = r_tmo + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= w_tmo_nxt;
    end
  end
`else
  assign w_tmo_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sum_nxt      = r_sum;
    w_m_valid_nxt  = r_m_valid;
    w_m_data_nxt   = r_m_data;
    w_m_last_nxt   = r_m_last;
    w_pkt_ok_nxt   = 1'b0;
    w_pkt_err_nxt  = 1'b0;
    w_err_code_nxt = r_err_code;

    if (r_m_valid && m_ready) w_m_valid_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_pop && r_data == SOF) w_state_nxt = LEN;
      end
      LEN: begin
        if (w_pop) begin
          if (r_data > LP_MAX_LEN) begin
            w_pkt_err_nxt  = 1'b1;
            w_err_code_nxt = ERR_LEN;
            w_state_nxt    = IDLE;
          end else begin
            w_cnt_nxt   = r_data;
            w_sum_nxt   = r_data;
            w_state_nxt = (r_data == 8'd0) ? CSUM : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (w_pop) begin
          w_m_data_nxt  = r_data;
          w_m_valid_nxt = 1'b1;
          w_m_last_nxt  = (r_cnt == 8'd1);
          w_sum_nxt     = w_sum_add;
          w_cnt_nxt     = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_nxt = CSUM;
        end
      end
      CSUM: begin
        if (w_pop) begin
          if (w_sum_add == 8'd0) begin
            w_pkt_ok_nxt = 1'b1;
          end else begin
            w_pkt_err_nxt  = 1'b1;
            w_err_code_nxt = ERR_CSUM;
          end
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_tmo_expire) begin
      w_pkt_err_nxt  = 1'b1;
      w_err_code_nxt = ERR_TIMEOUT;
      w_m_valid_nxt  = 1'b0;
      w_state_nxt    = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_sum      <= 8'd0;
      r_m_valid  <= 1'b0;
      r_m_data   <= 8'd0;
      r_m_last   <= 1'b0;
      r_pkt_ok   <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sum      <= w_sum_nxt;
      r_m_valid  <= w_m_valid_nxt;
      r_m_data   <= w_m_data_nxt;
      r_m_last   <= w_m_last_nxt;
      r_pkt_ok   <= w_pkt_ok_nxt;
      r_pkt_err  <= w_pkt_err_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  assign rd_uart  = w_pop;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_last   = r_m_last;
  assign pkt_ok   = r_pkt_ok;
  assign pkt_err  = r_pkt_err;
  assign err_code = r_err_code;
  assign busy     = (r_state != IDLE);

endmodule
